dmem_ctrl: RTL and testbench

// - Parametrised, multicycle data memory for the multicycle ARM core; successor to the single-cycle byte-enable data RAM.
// - Takes byte-addressed load/store requests over a valid/ready handshake and applies a configurable wait-state delay.
// - Performs byte-lane steering, partial stores and sign/zero-extended loads internally, then returns a response on a held valid/ready channel.

---
 rtl/dmem_ctrl.sv | 240 ++++++++++++++++++++++++
 tb/tb_dmem_ctrl.sv | 281 ++++++++++++++++++++++++++++
 2 files changed

// File: rtl/dmem_ctrl.sv
// dmem_ctrl: multicycle data memory for the multicycle ARM core.
// Byte-addressed load/store requests come in over a valid/ready handshake.
// Each access waits WAIT_CYC extra cycles, then returns a held response.
// Lane steering, partial stores and sign/zero extension are handled here.
// Optional feature: define DMEM_MISALIGN_TRAP_EN to flag misaligned accesses
// as errors. Without it, misaligned accesses are silently aligned down.
module dmem_ctrl #(
  parameter int DATA_W   = 32,
  parameter int DEPTH    = 512,
  parameter int WAIT_CYC = 1
) (
  input  logic              i_clk,
  input  logic              i_reset,
  input  logic              i_req_valid,
  output logic              o_req_ready,
  input  logic              i_req_we,
  input  logic [31:0]       i_req_addr,
  input  logic [1:0]        i_req_size,
  input  logic              i_req_signed,
  input  logic [DATA_W-1:0] i_req_wdata,
  output logic              o_resp_valid,
  input  logic              i_resp_ready,
  output logic [DATA_W-1:0] o_resp_rdata,
  output logic              o_resp_err
);

  localparam int BYTES = DATA_W / 8;
  localparam int OFFW  = $clog2(BYTES);
  localparam int AW    = $clog2(DEPTH);
  localparam logic [3:0] CNT_LOAD = (WAIT_CYC == 0) ? 4'd0 : 4'(WAIT_CYC - 1);

  typedef enum logic [1:0] {
    S_IDLE,
    S_WAIT,
    S_RESP
  } state_t;

  state_t            r_state;
  state_t            w_next;
  logic [3:0]        r_cnt;
  logic [3:0]        w_cnt_next;
  logic              w_accept;
  logic              w_commit;

  // Request captured at accept time; used when the access commits from WAIT.
  logic              r_we;
  logic [AW-1:0]     r_idx;
  logic [OFFW-1:0]   r_off;
  logic [1:0]        r_size;
  logic              r_signed;
  logic [DATA_W-1:0] r_wdata;

  // Request as seen at commit time (live inputs when committing straight from IDLE).
  logic              w_we;
  logic [AW-1:0]     w_idx;
  logic [OFFW-1:0]   w_off_raw;
  logic [OFFW-1:0]   w_off;
  logic [1:0]        w_size;
  logic              w_signed;
  logic [DATA_W-1:0] w_wdata;

  logic [OFFW-1:0]   w_lowmask;
  logic              w_misal;
  logic              w_size_ok;
  logic              w_err;
  logic [6:0]        w_nbits;
  logic [3:0]        w_nbytes;
  logic [3:0]        w_off4;
  logic [BYTES-1:0]  w_be;
  logic [DATA_W-1:0] w_wshift;
  logic [DATA_W-1:0] w_rword;
  logic [DATA_W-1:0] w_shifted;
  logic [DATA_W-1:0] w_ldata;
  logic              w_sbit;

  logic [DATA_W-1:0] r_mem [DEPTH];
  logic [DATA_W-1:0] r_rdata;
  logic              r_err;

  logic              w_unused_addr;

  assign w_unused_addr = ^i_req_addr[31:OFFW+AW];

  // State register and wait counter.
  always_ff @(posedge i_clk) begin
    if (i_reset) begin
      r_state <= S_IDLE;
      r_cnt   <= 4'd0;
    end else begin
      r_state <= w_next;
      r_cnt   <= w_cnt_next;
    end
  end

  // Next-state logic, handshake outputs and the commit strobe.
  always_comb begin
    w_next       = r_state;
    w_cnt_next   = r_cnt;
    w_accept     = 1'b0;
    w_commit     = 1'b0;
    o_req_ready  = 1'b0;
    o_resp_valid = 1'b0;
    case (r_state)
      S_IDLE: begin
        o_req_ready = 1'b1;
        if (i_req_valid) begin
          w_accept = 1'b1;
          if (WAIT_CYC == 0) begin
            w_next   = S_RESP;
            w_commit = 1'b1;
          end else begin
            w_next     = S_WAIT;
            w_cnt_next = CNT_LOAD;
          end
        end
      end
      S_WAIT: begin
        if (r_cnt == 4'd0) begin
          w_next   = S_RESP;
          w_commit = 1'b1;
        end else begin
          w_cnt_next = r_cnt - 4'd1;
        end
      end
      S_RESP: begin
        o_resp_valid = 1'b1;
        if (i_resp_ready) begin
          w_next = S_IDLE;
        end
      end
      default: begin
        w_next = S_IDLE;
      end
    endcase
  end

  // Capture the request on accept so the inputs are free to change afterwards.
  always_ff @(posedge i_clk) begin
    if (w_accept) begin
      r_we     <= i_req_we;
      r_idx    <= i_req_addr[OFFW +: AW];
      r_off    <= i_req_addr[OFFW-1:0];
      r_size   <= i_req_size;
      r_signed <= i_req_signed;
      r_wdata  <= i_req_wdata;
    end
  end

  // Select the request source and decode size, alignment and error.
  always_comb begin
    if (r_state == S_IDLE) begin
      w_we      = i_req_we;
      w_idx     = i_req_addr[OFFW +: AW];
      w_off_raw = i_req_addr[OFFW-1:0];
      w_size    = i_req_size;
      w_signed  = i_req_signed;
      w_wdata   = i_req_wdata;
    end else begin
      w_we      = r_we;
      w_idx     = r_idx;
      w_off_raw = r_off;
      w_size    = r_size;
      w_signed  = r_signed;
      w_wdata   = r_wdata;
    end
    w_lowmask = '0;
    for (int k = 0; k < OFFW; k++) begin
      if (k < int'(w_size)) begin
        w_lowmask[k] = 1'b1;
      end
    end
    w_misal   = |(w_off_raw & w_lowmask);
    w_size_ok = (w_size != 2'd3) || (DATA_W == 64);
`ifdef DMEM_MISALIGN_TRAP_EN
    w_off = w_off_raw;
    w_err = !w_size_ok || w_misal;
`else
    w_off = w_off_raw & ~w_lowmask;
    w_err = !w_size_ok;
`endif
    w_nbits  = 7'd8 << w_size;
    w_nbytes = 4'd1 << w_size;
    w_off4   = 4'(w_off);
  end

  // Store lane enables and data steered to the byte offset.
  always_comb begin
    w_wshift = w_wdata << {w_off, 3'b000};
    w_be     = '0;
    for (int b = 0; b < BYTES; b++) begin
      w_be[b] = (4'(b) >= w_off4) && (4'(b) < (w_off4 + w_nbytes));
    end
  end

  // Load path: shift the addressed bytes down, then sign- or zero-extend.
  always_comb begin
    w_rword   = r_mem[w_idx];
    w_shifted = w_rword >> {w_off, 3'b000};
    w_sbit    = 1'b0;
    for (int i = 0; i < DATA_W; i++) begin
      if (7'(i + 1) == w_nbits) begin
        w_sbit = w_shifted[i];
      end
    end
    w_ldata = '0;
    for (int i = 0; i < DATA_W; i++) begin
      if (7'(i) < w_nbits) begin
        w_ldata[i] = w_shifted[i];
      end else begin
        w_ldata[i] = w_signed & w_sbit;
      end
    end
  end

  // RAM write of the enabled lanes; a reset on the commit edge drops the store.
  always_ff @(posedge i_clk) begin
    if (w_commit && !i_reset && w_we && !w_err) begin
      for (int b = 0; b < BYTES; b++) begin
        if (w_be[b]) begin
          r_mem[w_idx][b*8 +: 8] <= w_wshift[b*8 +: 8];
        end
      end
    end
  end

  // Response data and error, registered on commit and held through RESP.
  always_ff @(posedge i_clk) begin
    if (i_reset) begin
      r_rdata <= '0;
      r_err   <= 1'b0;
    end else if (w_commit) begin
      r_err   <= w_err;
      r_rdata <= (w_we || w_err) ? '0 : w_ldata;
    end
  end

  assign o_resp_rdata = r_rdata;
  assign o_resp_err   = r_err;

endmodule

// File: tb/tb_dmem_ctrl.sv
// Testbench for dmem_ctrl (DATA_W=32, DEPTH=512, WAIT_CYC=3).
// A byte-array memory model with cycle-count timing predicts every output.
// Directed accesses also carry hand-computed literal results.
// Honours DMEM_MISALIGN_TRAP_EN the same way as the design.
module tb_dmem_ctrl;

  localparam int DW  = 32;
  localparam int DEP = 512;
  localparam int W   = 3;

  logic          clk = 1'b0;
  logic          rst;
  logic          reqValid;
  logic          reqReady;
  logic          reqWe;
  logic [31:0]   reqAddr;
  logic [1:0]    reqSize;
  logic          reqSigned;
  logic [DW-1:0] reqWdata;
  logic          respValid;
  logic          respReady;
  logic [DW-1:0] respRdata;
  logic          respErr;

  int   nVec = 0;
  int   nMis = 0;
  logic checkEn = 1'b0;

  logic [7:0]  mMem [0:2047];
  bit          mBusy = 1'b0;
  bit          mPostReset = 1'b0;
  int          mAge = 0;
  logic [31:0] mRdata = '0;
  logic        mErr = 1'b0;
  logic        mWe;
  logic [31:0] mAddr;
  logic [1:0]  mSize;
  logic        mSgn;
  logic [31:0] mWdata;

  always #5 clk = ~clk;

  dmem_ctrl #(.DATA_W(DW), .DEPTH(DEP), .WAIT_CYC(W)) dut (
    .i_clk        (clk),
    .i_reset      (rst),
    .i_req_valid  (reqValid),
    .o_req_ready  (reqReady),
    .i_req_we     (reqWe),
    .i_req_addr   (reqAddr),
    .i_req_size   (reqSize),
    .i_req_signed (reqSigned),
    .i_req_wdata  (reqWdata),
    .o_resp_valid (respValid),
    .i_resp_ready (respReady),
    .o_resp_rdata (respRdata),
    .o_resp_err   (respErr)
  );

  task automatic checkOutput(input string name, input logic [63:0] act, input logic [63:0] exp);
    nVec++;
    if (act !== exp) begin
      nMis++;
      $display("[TB] FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
    end
  endtask

  task automatic timeoutFail(input string name);
    nVec++;
    nMis++;
    $display("[TB] FAIL %s: timed out waiting on the DUT", name);
  endtask

  // Memory-level effect of one access on the byte array.
  task automatic modelCommit();
    int          n;
    int          base;
    logic        legal;
    logic        mis;
    logic [31:0] a;
    logic [63:0] v;
    n     = 1 << mSize;
    legal = (mSize != 2'd3);
    mis   = (mAddr % n) != 0;
`ifdef DMEM_MISALIGN_TRAP_EN
    mErr = !legal || mis;
    a    = mAddr;
`else
    mErr = !legal;
    a    = mAddr - (mAddr % n);
`endif
    base   = int'(a[10:0]);
    mRdata = '0;
    if (!mErr) begin
      if (mWe) begin
        for (int i = 0; i < n; i++) mMem[base + i] = mWdata[8*i +: 8];
      end else begin
        v = '0;
        for (int i = 0; i < n; i++) v = v | (64'(mMem[base + i]) << (8 * i));
        if (mSgn && v[8*n-1]) v = v | (~64'd0 << (8 * n));
        mRdata = v[31:0];
      end
    end
  endtask

  // Timing model: busy from accept until the response is taken; commit W edges after accept.
  always @(posedge clk) begin
    if (rst) begin
      mBusy      = 1'b0;
      mAge       = 0;
      mRdata     = '0;
      mErr       = 1'b0;
      mPostReset = 1'b1;
    end else begin
      mPostReset = 1'b0;
      if (!mBusy) begin
        if (reqValid) begin
          mWe    = reqWe;
          mAddr  = reqAddr;
          mSize  = reqSize;
          mSgn   = reqSigned;
          mWdata = reqWdata;
          mBusy  = 1'b1;
          mAge   = 0;
          if (W == 0) modelCommit();
        end
      end else if (mAge >= W) begin
        if (respReady) mBusy = 1'b0;
      end else begin
        mAge++;
        if (mAge == W) modelCommit();
      end
    end
  end

  // Per-cycle compare of every DUT output against the model.
  always @(negedge clk) begin
    if (checkEn) begin
      checkOutput("req_ready", reqReady, !mBusy);
      checkOutput("resp_valid", respValid, mBusy && (mAge >= W));
      if ((mBusy && (mAge >= W)) || mPostReset) begin
        checkOutput("resp_rdata", respRdata, mRdata);
        checkOutput("resp_err", respErr, mErr);
      end
    end
  end

  // One full transaction, junk on the request bus while busy, response held for 'hold' cycles.
  task automatic applyStimulus(input string tag, input logic we, input logic [31:0] addr,
                               input logic [1:0] size, input logic sgn, input logic [31:0] wdata,
                               input int hold, input logic [31:0] expRdata, input logic expErr);
    bit ok;
    int lat;
    ok = 1'b0;
    for (int k = 0; k < 40; k++) begin
      @(negedge clk);
      if (reqReady) begin
        ok = 1'b1;
        break;
      end
    end
    if (!ok) begin
      timeoutFail({tag, " ready"});
      return;
    end
    reqValid  = 1'b1;
    reqWe     = we;
    reqAddr   = addr;
    reqSize   = size;
    reqSigned = sgn;
    reqWdata  = wdata;
    respReady = 1'b0;
    @(posedge clk);
    @(negedge clk);
    reqWe     = 1'b1;
    reqAddr   = 32'h40;
    reqSize   = 2'd2;
    reqSigned = ~sgn;
    reqWdata  = '0;
    ok  = 1'b0;
    lat = 0;
    for (int k = 0; k < 40; k++) begin
      if (respValid) begin
        lat = k + 1;
        ok  = 1'b1;
        break;
      end
      @(posedge clk);
      @(negedge clk);
    end
    reqValid = 1'b0;
    if (!ok) begin
      timeoutFail({tag, " response"});
      return;
    end
    checkOutput({tag, " latency"}, lat, W + 1);
    repeat (hold) @(negedge clk);
    checkOutput({tag, " rdata"}, respRdata, expRdata);
    checkOutput({tag, " err"}, respErr, expErr);
    respReady = 1'b1;
    @(posedge clk);
    @(negedge clk);
    respReady = 1'b0;
  endtask

  initial begin
    #500000;
    $display("[TB] FAIL watchdog: simulation did not finish");
    $fatal(1, "[TB] watchdog expired");
  end

  initial begin
    rst       = 1'b1;
    reqValid  = 1'b0;
    reqWe     = 1'b0;
    reqAddr   = '0;
    reqSize   = '0;
    reqSigned = 1'b0;
    reqWdata  = '0;
    respReady = 1'b0;
    @(posedge clk);
    #1 checkEn = 1'b1;
    @(negedge clk);
    checkOutput("reset req_ready", reqReady, 1'b1);
    checkOutput("reset resp_valid", respValid, 1'b0);
    checkOutput("reset rdata", respRdata, 32'h0);
    checkOutput("reset err", respErr, 1'b0);
    rst = 1'b0;

    applyStimulus("SW 40", 1'b1, 32'h40, 2'd2, 1'b0, 32'hDEADBEEF, 0, 32'h0, 1'b0);
    applyStimulus("LW 40", 1'b0, 32'h40, 2'd2, 1'b0, 32'h0, 0, 32'hDEADBEEF, 1'b0);
    applyStimulus("LB 43 s", 1'b0, 32'h43, 2'd0, 1'b1, 32'h0, 0, 32'hFFFFFFDE, 1'b0);
    applyStimulus("LB 43 u", 1'b0, 32'h43, 2'd0, 1'b0, 32'h0, 0, 32'h000000DE, 1'b0);
    applyStimulus("SH 42", 1'b1, 32'h42, 2'd1, 1'b0, 32'hFFFF1234, 0, 32'h0, 1'b0);
    applyStimulus("LW 40 held", 1'b0, 32'h40, 2'd2, 1'b0, 32'h0, 2, 32'h1234BEEF, 1'b0);
    applyStimulus("LH 40 s", 1'b0, 32'h40, 2'd1, 1'b1, 32'h0, 0, 32'hFFFFBEEF, 1'b0);
    applyStimulus("LH 42 u", 1'b0, 32'h42, 2'd1, 1'b0, 32'h0, 1, 32'h00001234, 1'b0);
    applyStimulus("S size3", 1'b1, 32'h40, 2'd3, 1'b0, 32'hFFFFFFFF, 0, 32'h0, 1'b1);
    applyStimulus("LW alias 840", 1'b0, 32'h840, 2'd2, 1'b0, 32'h0, 0, 32'h1234BEEF, 1'b0);
`ifdef DMEM_MISALIGN_TRAP_EN
    applyStimulus("SW 41 mis", 1'b1, 32'h41, 2'd2, 1'b0, 32'hA5A5A5A5, 0, 32'h0, 1'b1);
    applyStimulus("LW 40 after mis", 1'b0, 32'h40, 2'd2, 1'b0, 32'h0, 0, 32'h1234BEEF, 1'b0);
    applyStimulus("LH 41 mis", 1'b0, 32'h41, 2'd1, 1'b0, 32'h0, 0, 32'h0, 1'b1);
`else
    applyStimulus("SW 41 mis", 1'b1, 32'h41, 2'd2, 1'b0, 32'hA5A5A5A5, 0, 32'h0, 1'b0);
    applyStimulus("LW 40 after mis", 1'b0, 32'h40, 2'd2, 1'b0, 32'h0, 0, 32'hA5A5A5A5, 1'b0);
    applyStimulus("LH 41 mis", 1'b0, 32'h41, 2'd1, 1'b0, 32'h0, 0, 32'h0000A5A5, 1'b0);
`endif
    applyStimulus("SW 44", 1'b1, 32'h44, 2'd2, 1'b0, 32'h0, 0, 32'h0, 1'b0);
    applyStimulus("SB 45", 1'b1, 32'h45, 2'd0, 1'b0, 32'hFFFFFF77, 0, 32'h0, 1'b0);
    applyStimulus("LW 44", 1'b0, 32'h44, 2'd2, 1'b0, 32'h0, 0, 32'h00007700, 1'b0);
    applyStimulus("LB 45 u", 1'b0, 32'h45, 2'd0, 1'b0, 32'h0, 0, 32'h00000077, 1'b0);

    applyStimulus("SW 80", 1'b1, 32'h80, 2'd2, 1'b0, 32'h11223344, 0, 32'h0, 1'b0);
    applyStimulus("LW 80", 1'b0, 32'h80, 2'd2, 1'b0, 32'h0, 0, 32'h11223344, 1'b0);

    // Store to 0x80 aborted by a reset while it is still waiting.
    @(negedge clk);
    checkOutput("abort pre ready", reqReady, 1'b1);
    reqValid = 1'b1;
    reqWe    = 1'b1;
    reqAddr  = 32'h80;
    reqSize  = 2'd2;
    reqWdata = 32'hCAFEF00D;
    @(posedge clk);
    @(negedge clk);
    reqValid = 1'b0;
    rst      = 1'b1;
    @(negedge clk);
    rst = 1'b0;
    checkOutput("abort req_ready", reqReady, 1'b1);
    checkOutput("abort resp_valid", respValid, 1'b0);
    checkOutput("abort rdata", respRdata, 32'h0);
    checkOutput("abort err", respErr, 1'b0);
    applyStimulus("LW 80 after abort", 1'b0, 32'h80, 2'd2, 1'b0, 32'h0, 0, 32'h11223344, 1'b0);

    repeat (3) @(negedge clk);
    $display("== %0d vectors applied, %0d miscompares ==", nVec, nMis);
    $finish;
  end

endmodule
